// File: rtl/ps2_rx_if.sv
// Byte-side bundle of the PS/2 receiver: receive enable in, received byte and status pulses out.
// The receiver takes the slave view; the scan-code stage that consumes bytes takes the master view.
interface ps2_rx_if;
    logic       rx_en;
    logic       rx_done_tick;
    logic [7:0] dout;
    logic       parity_err;
    logic       frame_err;

    modport master (
        output rx_en,
        input  rx_done_tick,
        input  dout,
        input  parity_err,
        input  frame_err
    );

    modport slave (
        input  rx_en,
        output rx_done_tick,
        output dout,
        output parity_err,
        output frame_err
    );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronises and de-glitches ps2c/ps2d, deserialises 11-bit
// frames, and reports good bytes, parity errors and framing/timeout errors as one-cycle pulses.
module ps2_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    ps2d,
    input  logic    ps2c,
    ps2_rx_if.slave bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DPS,
        LOAD
    } state_t;

    logic                  ps2c_meta, ps2c_sync;
    logic                  ps2d_meta, ps2d_sync;
    logic [FILTER_LEN-1:0] filter_reg;
    logic                  f_ps2c, f_ps2c_d;
    logic                  fall_edge;

    state_t                state_reg, state_next;
    logic [3:0]            n_reg, n_next;
    logic [10:0]           b_reg, b_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next, cnt_inc;
    logic [7:0]            dout_reg, dout_next;
    logic                  rx_done, par_err, frm_err;

    // The filtered clock only moves once FILTER_LEN identical samples have been seen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ps2c_meta  <= 1'b1;
            ps2c_sync  <= 1'b1;
            ps2d_meta  <= 1'b1;
            ps2d_sync  <= 1'b1;
            filter_reg <= '1;
            f_ps2c     <= 1'b1;
            f_ps2c_d   <= 1'b1;
        end else begin
            ps2c_meta  <= ps2c;
            ps2c_sync  <= ps2c_meta;
            ps2d_meta  <= ps2d;
            ps2d_sync  <= ps2d_meta;
            filter_reg <= {ps2c_sync, filter_reg[FILTER_LEN-1:1]};
            if (filter_reg == '1) begin
                f_ps2c <= 1'b1;
            end else if (filter_reg == '0) begin
                f_ps2c <= 1'b0;
            end
            f_ps2c_d <= f_ps2c;
        end
    end

    assign fall_edge = f_ps2c_d & ~f_ps2c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            n_reg     <= '0;
            b_reg     <= '0;
            cnt_reg   <= '0;
            dout_reg  <= '0;
        end else begin
            state_reg <= state_next;
            n_reg     <= n_next;
            b_reg     <= b_next;
            cnt_reg   <= cnt_next;
            dout_reg  <= dout_next;
        end
    end

    assign cnt_inc = cnt_reg + 1'b1;

    // The watchdog fires in the cycle its count reaches the limit, so an abort lands
    // TIMEOUT_CYCLES-1 cycles after the last falling edge.
    always_comb begin
        state_next = state_reg;
        n_next     = n_reg;
        b_next     = b_reg;
        cnt_next   = cnt_reg;
        dout_next  = dout_reg;
        rx_done    = 1'b0;
        par_err    = 1'b0;
        frm_err    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (fall_edge && bus.rx_en) begin
                    b_next     = {ps2d_sync, b_reg[10:1]};
                    n_next     = 4'd9;
                    cnt_next   = '0;
                    state_next = DPS;
                end
            end
            DPS: begin
                if (fall_edge) begin
                    b_next   = {ps2d_sync, b_reg[10:1]};
                    cnt_next = '0;
                    if (n_reg == 4'd0) begin
                        state_next = LOAD;
                    end else begin
                        n_next = n_reg - 4'd1;
                    end
                end else if (cnt_inc == CNT_LIMIT) begin
                    frm_err    = 1'b1;
                    n_next     = '0;
                    b_next     = '0;
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            LOAD: begin
                state_next = IDLE;
                if (b_reg[0] != 1'b0 || b_reg[10] != 1'b1) begin
                    frm_err = 1'b1;
                end else if (^b_reg[9:1] == 1'b0) begin
                    par_err = 1'b1;
                end else begin
                    dout_next = b_reg[8:1];
                    rx_done   = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.rx_done_tick = rx_done;
    assign bus.parity_err   = par_err;
    assign bus.frame_err    = frm_err;
    assign bus.dout         = dout_reg;

endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
PS/2 device-to-host serial receiver that sits directly upstream of the keyboard scan-code stage. It synchronises and de-glitches ps2c and ps2d, then deserialises each 11-bit frame (start, 8 data LSB-first, odd parity, stop). It emits one-cycle pulses for good bytes and for errored frames. A watchdog aborts stalled frames.

Parameters:
FILTER_LEN, 8, number of consecutive identical synchronised ps2c samples needed to change the filtered clock level (range 2..16)
TIMEOUT_CYCLES, 50000, clk cycles allowed between falling edges inside a frame before abort (1 ms at 50 MHz)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset; 0 = reset
ps2d  input  1  raw PS/2 data line, asynchronous
ps2c  input  1  raw PS/2 clock line, asynchronous
rx_en  input  1  1 = new frames may start; sampled only in IDLE
rx_done_tick  output  1  one-cycle pulse, dout holds a new valid byte
dout  output  8  last good received byte
parity_err  output  1  one-cycle pulse, frame had a parity error
frame_err  output  1  one-cycle pulse, bad start/stop bit or timeout

Behaviour:
- Reset (reset=0, async): all outputs 0; state IDLE; synchronisers and filter shift register to all-ones; filtered clock=1; bit counter, shift register, timeout counter=0.
- Input conditioning: two-flop synchroniser on each of ps2c and ps2d.
- Filter: FILTER_LEN-bit shift register of synchronised ps2c.
  - All ones -> filtered clock 1.
  - All zeros -> filtered clock 0.
  - Otherwise the filtered clock holds its level.
- Edge detect: registered filtered clock. fall_edge is a one-cycle strobe on a 1->0 transition. Synchronised ps2d is sampled in the same cycle as fall_edge.
- FSM states: IDLE, DPS, LOAD.
  - IDLE: on fall_edge with rx_en=1, shift ps2d into b_reg[10], set n=9, clear timeout counter, go to DPS. A fall_edge with rx_en=0 is ignored.
  - DPS: on each fall_edge, b_reg <= {ps2d, b_reg[10:1]}. If n==0, go to LOAD; otherwise decrement n. After the 11th bit, b_reg[0]=start, b_reg[8:1]=data, b_reg[9]=parity, b_reg[10]=stop.
  - DPS ignores rx_en; a frame in progress always completes.
  - DPS watchdog: the timeout counter increments every cycle with no fall_edge and clears on fall_edge. When it reaches TIMEOUT_CYCLES-1, pulse frame_err for one cycle, clear n and b_reg, go to IDLE.
  - LOAD (exactly one cycle), evaluated in this priority order:
    1. b_reg[0]!=0 or b_reg[10]!=1: frame_err=1.
    2. Else XOR of b_reg[9:1] == 0: parity_err=1.
    3. Else dout <= b_reg[8:1] and rx_done_tick=1.
  - LOAD always returns to IDLE on the next cycle.
- Only one of rx_done_tick, parity_err, frame_err is high in any cycle.
- dout is updated only on good frames and holds across errored frames.
- Latency: raw ps2c fall to fall_edge strobe = 2 + FILTER_LEN + 1 cycles. rx_done_tick is asserted the cycle after the fall_edge that samples the stop bit.
- Glitches on ps2c shorter than FILTER_LEN cycles produce no edge.
- A fall_edge arriving during the LOAD cycle is ignored. The PS/2 clock period makes this unreachable in normal operation.
- reset asserted mid-frame aborts the frame immediately with no pulses. The first frame after reset release is received normally.

Test Plan:
- Good frame, ps2c period 60 us, clk 50 MHz. Bits: start 0, data 0x1C LSB-first (0,0,1,1,1,0,0,0), parity 0, stop 1. Required: exactly one rx_done_tick; dout=0x1C; no error pulses.
- Same frame with parity bit 1. Required: one parity_err pulse; no rx_done_tick; dout keeps its previous value (0x1C, or 0x00 after reset).
- Good 0x1C frame with a 3-cycle low glitch on ps2c in the middle of data bit 4 (FILTER_LEN=8). Required: frame received intact, dout=0x1C. Second case: stop bit 0 -> frame_err pulse only.
- Send 5 bits, then hold ps2c high for more than TIMEOUT_CYCLES. Required: one frame_err pulse exactly TIMEOUT_CYCLES-1 cycles after the last fall_edge. A following good 0xF0 frame yields dout=0xF0 and rx_done_tick.
- rx_en=0 during a full frame -> no outputs. Then rx_en=1 at the start of a 0x29 frame, dropped to 0 after bit 3. Required: frame completes, dout=0x29.
- Assert reset=0 after bit 6 of a frame. Required: all outputs 0 immediately; after release, a good 0x5A frame gives dout=0x5A.
